// File: rtl/reg_bank_fwd.sv
// Register bank for the 16-bit MIPS core. It owns the register file and a destination-tag
// pipeline that forwards in-flight results to the operands and stalls on load-use hazards.
module reg_bank_fwd #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int R0_ZERO   = 1,
    localparam int SEL_W    = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [ADDR_W-1:0]             ra,
    input  logic [ADDR_W-1:0]             rb,
    input  logic [ADDR_W-1:0]             rw,
    input  logic                          rw_en,
    input  logic                          is_load,
    input  logic [DATA_W-1:0]             imm,
    input  logic                          imm_sel,
    input  logic                          flush,
    input  logic [FWD_DEPTH*DATA_W-1:0]   stage_data,
    output logic [DATA_W-1:0]             A,
    output logic [DATA_W-1:0]             B,
    output logic                          ex_valid,
    output logic [SEL_W-1:0]              mux_sel_A,
    output logic [SEL_W-1:0]              mux_sel_B,
    output logic                          stall
);

    localparam int NREG = 2 ** ADDR_W;
    // With a single stage, EX is also commit, so a load tag there is already backed by data.
    localparam bit LOAD_AT_EX_BLOCKS = (FWD_DEPTH > 1);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] idx;
        logic              ld;
    } tag_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
    } operand_t;

    tag_t              dst [FWD_DEPTH];
    logic [DATA_W-1:0] regfile [NREG];

    operand_t op_a;
    operand_t op_b;
    logic     issue;
    logic     r0_target;

    // Scanning from the oldest stage down lets the youngest matching stage overwrite the rest.
    function automatic operand_t resolve(input logic [ADDR_W-1:0] s);
        operand_t r;
        r.data = regfile[s];
        r.sel  = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (dst[k].valid && dst[k].idx == s &&
                !(k == 0 && dst[k].ld && LOAD_AT_EX_BLOCKS)) begin
                r.data = stage_data[k*DATA_W +: DATA_W];
                r.sel  = SEL_W'(k + 1);
            end
        end
        if (R0_ZERO != 0 && s == '0) begin
            r.data = '0;
            r.sel  = '0;
        end
        return r;
    endfunction

    always_comb begin
        op_a = resolve(ra);
        op_b = resolve(rb);
        if (imm_sel) begin
            op_b.data = imm;
            op_b.sel  = '0;
        end
    end

    always_comb begin
        stall = LOAD_AT_EX_BLOCKS && id_valid && !flush && dst[0].valid && dst[0].ld &&
                (dst[0].idx == ra || (!imm_sel && dst[0].idx == rb));
        issue     = id_valid && !stall && !flush;
        r0_target = (R0_ZERO != 0) && (rw == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                dst[k] <= '0;
            end
            for (int i = 0; i < NREG; i++) begin
                regfile[i] <= '0;
            end
            A         <= '0;
            B         <= '0;
            mux_sel_A <= '0;
            mux_sel_B <= '0;
            ex_valid  <= 1'b0;
        end else begin
            dst[0].valid <= issue && rw_en && !r0_target;
            dst[0].idx   <= rw;
            dst[0].ld    <= is_load;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                dst[k] <= dst[k-1];
            end
            if (dst[FWD_DEPTH-1].valid) begin
                regfile[dst[FWD_DEPTH-1].idx] <= stage_data[(FWD_DEPTH-1)*DATA_W +: DATA_W];
            end
            ex_valid <= issue;
            // A bubble leaves the operand registers untouched.
            if (issue) begin
                A         <= op_a.data;
                B         <= op_b.data;
                mux_sel_A <= op_a.sel;
                mux_sel_B <= op_b.sel;
            end
        end
    end

endmodule
